// File: rtl/ccip_mem_responder.sv
// ccip_mem_responder: CCI-P host-side responder backed by an on-chip line memory.
// Read (c0) and write (c1) requests each land in their own FIFO; every
// non-empty FIFO pops one entry per cycle into a dual-port line memory.
// Read latency is 3 cycles and write-ack latency 2 cycles from acceptance.
// Optional macro CCIP_RESPONDER_DELAY_EN inserts an RSP_DELAY-stage shift
// pipeline in front of the response output registers.
module ccip_mem_responder #(
  parameter int MEM_LINES      = 1024,
  parameter int FIFO_DEPTH     = 16,
  parameter int ALM_FULL_SLACK = 8,
  parameter int RSP_DELAY      = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         c0_tx_valid,
  input  logic [41:0]  c0_tx_addr,
  input  logic [15:0]  c0_tx_mdata,
  input  logic         c1_tx_valid,
  input  logic [41:0]  c1_tx_addr,
  input  logic [15:0]  c1_tx_mdata,
  input  logic [511:0] c1_tx_data,
  output logic         c0_tx_alm_full,
  output logic         c1_tx_alm_full,
  output logic         c0_rx_rsp_valid,
  output logic [15:0]  c0_rx_mdata,
  output logic [511:0] c0_rx_data,
  output logic         c1_rx_rsp_valid,
  output logic [15:0]  c1_rx_mdata,
  output logic [31:0]  rd_count,
  output logic [31:0]  wr_count,
  output logic         overflow
);

  localparam int IDX_W = $clog2(MEM_LINES);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_LVL = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] ALM_LVL  = CNT_W'(FIFO_DEPTH - ALM_FULL_SLACK);

  // Request FIFO storage (only the memory index bits of the address are kept)
  logic [IDX_W-1:0] r_c0_q_idx   [FIFO_DEPTH];
  logic [15:0]      r_c0_q_mdata [FIFO_DEPTH];
  logic [IDX_W-1:0] r_c1_q_idx   [FIFO_DEPTH];
  logic [15:0]      r_c1_q_mdata [FIFO_DEPTH];
  logic [511:0]     r_c1_q_data  [FIFO_DEPTH];

  logic [PTR_W-1:0] r_c0_wptr, r_c0_rptr, r_c1_wptr, r_c1_rptr;
  logic [CNT_W-1:0] r_c0_count, r_c1_count;
  logic [CNT_W-1:0] w_c0_cnt_nxt, w_c1_cnt_nxt;
  logic             w_c0_push, w_c0_pop, w_c0_drop;
  logic             w_c1_push, w_c1_pop, w_c1_drop;

  // Debug hook: holding this high parks read requests in the c0 FIFO.
  logic             w_c0_pop_hold;

  logic [511:0]     r_mem [MEM_LINES];

  logic             r_rd_vld_p0, r_rd_vld_p1, r_wr_vld_p0;
  logic [15:0]      r_rd_mdata_p0, r_rd_mdata_p1, r_wr_mdata_p0;
  logic [511:0]     r_rd_data_p0, r_rd_data_p1;

  logic             w_rd_vld_d, w_wr_vld_d;
  logic [15:0]      w_rd_mdata_d, w_wr_mdata_d;
  logic [511:0]     w_rd_data_d;

  logic             w_unused;

  assign w_c0_pop_hold = 1'b0;
  assign w_unused      = (^{c0_tx_addr[41:IDX_W], c1_tx_addr[41:IDX_W]}) ^ (RSP_DELAY > 0);

  // A full FIFO still accepts when the same-cycle pop frees a slot.
  assign w_c0_pop     = (r_c0_count != '0) && !w_c0_pop_hold && !reset;
  assign w_c0_push    = c0_tx_valid && !reset && ((r_c0_count != FULL_LVL) || w_c0_pop);
  assign w_c0_drop    = c0_tx_valid && !reset && !w_c0_push;
  assign w_c0_cnt_nxt = r_c0_count + CNT_W'(w_c0_push) - CNT_W'(w_c0_pop);

  assign w_c1_pop     = (r_c1_count != '0) && !reset;
  assign w_c1_push    = c1_tx_valid && !reset && ((r_c1_count != FULL_LVL) || w_c1_pop);
  assign w_c1_drop    = c1_tx_valid && !reset && !w_c1_push;
  assign w_c1_cnt_nxt = r_c1_count + CNT_W'(w_c1_push) - CNT_W'(w_c1_pop);

  // FIFO payload writes on push
  always_ff @(posedge clk) begin
    if (w_c0_push) begin
      r_c0_q_idx[r_c0_wptr]   <= c0_tx_addr[IDX_W-1:0];
      r_c0_q_mdata[r_c0_wptr] <= c0_tx_mdata;
    end
    if (w_c1_push) begin
      r_c1_q_idx[r_c1_wptr]   <= c1_tx_addr[IDX_W-1:0];
      r_c1_q_mdata[r_c1_wptr] <= c1_tx_mdata;
      r_c1_q_data[r_c1_wptr]  <= c1_tx_data;
    end
  end

  // FIFO pointers, occupancy and registered almost-full flags
  always_ff @(posedge clk) begin
    if (reset) begin
      r_c0_wptr      <= '0;
      r_c0_rptr      <= '0;
      r_c0_count     <= '0;
      r_c1_wptr      <= '0;
      r_c1_rptr      <= '0;
      r_c1_count     <= '0;
      c0_tx_alm_full <= 1'b0;
      c1_tx_alm_full <= 1'b0;
    end else begin
      if (w_c0_push) r_c0_wptr <= r_c0_wptr + PTR_W'(1);
      if (w_c0_pop)  r_c0_rptr <= r_c0_rptr + PTR_W'(1);
      if (w_c1_push) r_c1_wptr <= r_c1_wptr + PTR_W'(1);
      if (w_c1_pop)  r_c1_rptr <= r_c1_rptr + PTR_W'(1);
      r_c0_count     <= w_c0_cnt_nxt;
      r_c1_count     <= w_c1_cnt_nxt;
      c0_tx_alm_full <= (w_c0_cnt_nxt >= ALM_LVL);
      c1_tx_alm_full <= (w_c1_cnt_nxt >= ALM_LVL);
    end
  end

  // Acceptance counters and sticky overflow
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_count <= '0;
      wr_count <= '0;
      overflow <= 1'b0;
    end else begin
      if (w_c0_push) rd_count <= rd_count + 32'd1;
      if (w_c1_push) wr_count <= wr_count + 32'd1;
      if (w_c0_drop || w_c1_drop) overflow <= 1'b1;
    end
  end

  // ---- stage p0: pop; memory write and read-first memory read ----
  always_ff @(posedge clk) begin
    if (w_c1_pop) begin
      r_mem[r_c1_q_idx[r_c1_rptr]] <= r_c1_q_data[r_c1_rptr];
      r_wr_mdata_p0                <= r_c1_q_mdata[r_c1_rptr];
    end
    if (w_c0_pop) begin
      r_rd_data_p0  <= r_mem[r_c0_q_idx[r_c0_rptr]];
      r_rd_mdata_p0 <= r_c0_q_mdata[r_c0_rptr];
    end
  end

  // ---- stage p1: read data register ----
  always_ff @(posedge clk) begin
    r_rd_mdata_p1 <= r_rd_mdata_p0;
    r_rd_data_p1  <= r_rd_data_p0;
  end

  // Response valids for stages p0/p1
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_vld_p0 <= 1'b0;
      r_rd_vld_p1 <= 1'b0;
      r_wr_vld_p0 <= 1'b0;
    end else begin
      r_rd_vld_p0 <= w_c0_pop;
      r_rd_vld_p1 <= r_rd_vld_p0;
      r_wr_vld_p0 <= w_c1_pop;
    end
  end

`ifdef CCIP_RESPONDER_DELAY_EN
  logic         r_rd_vld_dly   [RSP_DELAY];
  logic [15:0]  r_rd_mdata_dly [RSP_DELAY];
  logic [511:0] r_rd_data_dly  [RSP_DELAY];
  logic         r_wr_vld_dly   [RSP_DELAY];
  logic [15:0]  r_wr_mdata_dly [RSP_DELAY];

  // ---- delay stages: valid shift chain, flushed by reset ----
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < RSP_DELAY; i++) begin
        r_rd_vld_dly[i] <= 1'b0;
        r_wr_vld_dly[i] <= 1'b0;
      end
    end else begin
      r_rd_vld_dly[0] <= r_rd_vld_p1;
      r_wr_vld_dly[0] <= r_wr_vld_p0;
      for (int i = 1; i < RSP_DELAY; i++) begin
        r_rd_vld_dly[i] <= r_rd_vld_dly[i-1];
        r_wr_vld_dly[i] <= r_wr_vld_dly[i-1];
      end
    end
  end

  // Delay stages: payload shift chain
  always_ff @(posedge clk) begin
    r_rd_mdata_dly[0] <= r_rd_mdata_p1;
    r_rd_data_dly[0]  <= r_rd_data_p1;
    r_wr_mdata_dly[0] <= r_wr_mdata_p0;
    for (int i = 1; i < RSP_DELAY; i++) begin
      r_rd_mdata_dly[i] <= r_rd_mdata_dly[i-1];
      r_rd_data_dly[i]  <= r_rd_data_dly[i-1];
      r_wr_mdata_dly[i] <= r_wr_mdata_dly[i-1];
    end
  end

  assign w_rd_vld_d   = r_rd_vld_dly[RSP_DELAY-1];
  assign w_rd_mdata_d = r_rd_mdata_dly[RSP_DELAY-1];
  assign w_rd_data_d  = r_rd_data_dly[RSP_DELAY-1];
  assign w_wr_vld_d   = r_wr_vld_dly[RSP_DELAY-1];
  assign w_wr_mdata_d = r_wr_mdata_dly[RSP_DELAY-1];
`else
  assign w_rd_vld_d   = r_rd_vld_p1;
  assign w_rd_mdata_d = r_rd_mdata_p1;
  assign w_rd_data_d  = r_rd_data_p1;
  assign w_wr_vld_d   = r_wr_vld_p0;
  assign w_wr_mdata_d = r_wr_mdata_p0;
`endif

  // ---- output registers: single-cycle response pulses ----
  always_ff @(posedge clk) begin
    if (reset) begin
      c0_rx_rsp_valid <= 1'b0;
      c0_rx_mdata     <= '0;
      c0_rx_data      <= '0;
      c1_rx_rsp_valid <= 1'b0;
      c1_rx_mdata     <= '0;
    end else begin
      c0_rx_rsp_valid <= w_rd_vld_d;
      c1_rx_rsp_valid <= w_wr_vld_d;
      if (w_rd_vld_d) begin
        c0_rx_mdata <= w_rd_mdata_d;
        c0_rx_data  <= w_rd_data_d;
      end
      if (w_wr_vld_d) begin
        c1_rx_mdata <= w_wr_mdata_d;
      end
    end
  end

endmodule

// File: tb/tb_ccip_mem_responder.sv
// Testbench for ccip_mem_responder: scoreboard queues filled at issue time
// from a line-array memory model, drained by an independent response monitor.
module tb_ccip_mem_responder;

  localparam int MEM_LINES = 1024;
`ifdef CCIP_RESPONDER_DELAY_EN
  localparam int EXTRA = 32;
`else
  localparam int EXTRA = 0;
`endif
  localparam int RD_LAT = 3 + EXTRA;
  localparam int WR_LAT = 2 + EXTRA;

  logic         clk = 1'b0;
  logic         reset;
  logic         c0_tx_valid;
  logic [41:0]  c0_tx_addr;
  logic [15:0]  c0_tx_mdata;
  logic         c1_tx_valid;
  logic [41:0]  c1_tx_addr;
  logic [15:0]  c1_tx_mdata;
  logic [511:0] c1_tx_data;
  logic         c0_tx_alm_full, c1_tx_alm_full;
  logic         c0_rx_rsp_valid;
  logic [15:0]  c0_rx_mdata;
  logic [511:0] c0_rx_data;
  logic         c1_rx_rsp_valid;
  logic [15:0]  c1_rx_mdata;
  logic [31:0]  rd_count, wr_count;
  logic         overflow;

  ccip_mem_responder #(
    .MEM_LINES(MEM_LINES), .FIFO_DEPTH(16), .ALM_FULL_SLACK(8), .RSP_DELAY(32)
  ) dut (
    .clk(clk), .reset(reset),
    .c0_tx_valid(c0_tx_valid), .c0_tx_addr(c0_tx_addr), .c0_tx_mdata(c0_tx_mdata),
    .c1_tx_valid(c1_tx_valid), .c1_tx_addr(c1_tx_addr), .c1_tx_mdata(c1_tx_mdata),
    .c1_tx_data(c1_tx_data),
    .c0_tx_alm_full(c0_tx_alm_full), .c1_tx_alm_full(c1_tx_alm_full),
    .c0_rx_rsp_valid(c0_rx_rsp_valid), .c0_rx_mdata(c0_rx_mdata), .c0_rx_data(c0_rx_data),
    .c1_rx_rsp_valid(c1_rx_rsp_valid), .c1_rx_mdata(c1_rx_mdata),
    .rd_count(rd_count), .wr_count(wr_count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct { logic [15:0] m; logic [511:0] d; int unsigned c; bit t; } rexp_t;
  typedef struct { logic [15:0] m; int unsigned c; bit t; } wexp_t;

  rexp_t        rdq[$];
  wexp_t        wrq[$];
  rexp_t        mon_r;
  wexp_t        mon_w;
  int           checks = 0;
  int           failures = 0;
  int unsigned  cyc = 0;
  int unsigned  exp_rd = 0;
  int unsigned  exp_wr = 0;
  logic [511:0] mem_model [MEM_LINES];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask

  task automatic chkd(input string n, input logic [511:0] a, input logic [511:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask

  function automatic int idx(input logic [41:0] a);
    return int'(a % 42'(MEM_LINES));
  endfunction

  function automatic logic [511:0] rnd512();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Response monitor: every response must match the oldest expectation
  always @(negedge clk) begin
    if (c0_rx_rsp_valid === 1'b1) begin
      if (rdq.size() == 0) begin
        checks++; failures++;
        $display("FAIL rd_unexpected: got read response mdata %0h, expected none", c0_rx_mdata);
      end else begin
        mon_r = rdq.pop_front();
        chk("rd_mdata", 64'(c0_rx_mdata), 64'(mon_r.m));
        chkd("rd_data", c0_rx_data, mon_r.d);
        if (mon_r.t) chk("rd_latency", 64'(cyc), 64'(mon_r.c));
      end
    end
    if (c1_rx_rsp_valid === 1'b1) begin
      if (wrq.size() == 0) begin
        checks++; failures++;
        $display("FAIL wr_unexpected: got write ack mdata %0h, expected none", c1_rx_mdata);
      end else begin
        mon_w = wrq.pop_front();
        chk("wr_mdata", 64'(c1_rx_mdata), 64'(mon_w.m));
        if (mon_w.t) chk("wr_latency", 64'(cyc), 64'(mon_w.c));
      end
    end
  end

  // One cycle of stimulus; expectations come from the model at issue time.
  // Both channels pop one cycle after issue, so a same-cycle read sees the
  // line before the same-cycle write.
  task automatic drive(input bit v0, input logic [41:0] a0, input logic [15:0] m0,
                       input bit v1, input logic [41:0] a1, input logic [15:0] m1,
                       input logic [511:0] d1);
    rexp_t r;
    wexp_t w;
    c0_tx_valid = v0; c0_tx_addr = a0; c0_tx_mdata = m0;
    c1_tx_valid = v1; c1_tx_addr = a1; c1_tx_mdata = m1; c1_tx_data = d1;
    if (v0) begin
      r.m = m0; r.d = mem_model[idx(a0)]; r.c = cyc + 32'(1 + RD_LAT); r.t = 1'b1;
      rdq.push_back(r);
      exp_rd++;
    end
    if (v1) begin
      mem_model[idx(a1)] = d1;
      w.m = m1; w.c = cyc + 32'(1 + WR_LAT); w.t = 1'b1;
      wrq.push_back(w);
      exp_wr++;
    end
    @(posedge clk); #1;
    c0_tx_valid = 1'b0;
    c1_tx_valid = 1'b0;
  endtask

  task automatic rd(input logic [41:0] a, input logic [15:0] m);
    drive(1'b1, a, m, 1'b0, '0, '0, '0);
  endtask

  task automatic wr(input logic [41:0] a, input logic [15:0] m, input logic [511:0] d);
    drive(1'b0, '0, '0, 1'b1, a, m, d);
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while ((rdq.size() != 0 || wrq.size() != 0) && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    chk("rd_drain", 64'(rdq.size()), 64'd0);
    chk("wr_drain", 64'(wrq.size()), 64'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [511:0] la, lb, ld;
    logic [41:0]  a;
    rexp_t        r;
    int           occ;
    bit           v0, v1;

    reset = 1'b1;
    c0_tx_valid = 1'b0; c0_tx_addr = '0; c0_tx_mdata = '0;
    c1_tx_valid = 1'b0; c1_tx_addr = '0; c1_tx_mdata = '0; c1_tx_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_c0_valid", 64'(c0_rx_rsp_valid), 64'd0);
    chk("rst_c1_valid", 64'(c1_rx_rsp_valid), 64'd0);
    chk("rst_c0_mdata", 64'(c0_rx_mdata), 64'd0);
    chkd("rst_c0_data", c0_rx_data, '0);
    chk("rst_c1_mdata", 64'(c1_rx_mdata), 64'd0);
    chk("rst_c0_alm", 64'(c0_tx_alm_full), 64'd0);
    chk("rst_c1_alm", 64'(c1_tx_alm_full), 64'd0);
    chk("rst_rd_count", 64'(rd_count), 64'd0);
    chk("rst_wr_count", 64'(wr_count), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Write then read back
    wr(42'h5, 16'h00A1, {16{32'hDEADBEEF}});
    rd(42'h5, 16'h00B2);
    wait_drain(200);
    chk("wb_rd_count", 64'(rd_count), 64'd1);
    chk("wb_wr_count", 64'(wr_count), 64'd1);

    // Fill every line with known data
    for (int i = 0; i < MEM_LINES; i++) wr(42'(i), 16'(i), rnd512());
    wait_drain(200);

    // Streaming reads and address aliasing
    for (int i = 0; i < 16; i++) rd(42'(i), 16'(i));
    rd(42'h400, 16'h0400);
    rd(42'h3_0000_0007, 16'h0777);
    wait_drain(200);

    // Same-cycle same-line read/write hazard
    la = rnd512();
    lb = rnd512();
    wr(42'h3, 16'h0A0A, la);
    repeat (4) begin @(posedge clk); #1; end
    drive(1'b1, 42'h3, 16'h0C0C, 1'b1, 42'h3, 16'h0B0B, lb);
    rd(42'h3, 16'h0D0D);
    wait_drain(200);
    chkd("hazard_model_old", la, la ^ lb ^ lb);

    // Randomized mixed traffic, biased towards a few hot lines
    repeat (400) begin
      v0 = ($urandom_range(0, 9) < 6);
      v1 = ($urandom_range(0, 9) < 5);
      a = ($urandom_range(0, 2) == 0) ? 42'($urandom_range(0, 7)) : {10'($urandom), $urandom};
      ld = rnd512();
      drive(v0, a, 16'($urandom),
            v1, ($urandom_range(0, 1) == 0) ? a : {10'($urandom), $urandom},
            16'($urandom), ld);
    end
    wait_drain(200);
    chk("rand_rd_count", 64'(rd_count), 64'(exp_rd));
    chk("rand_wr_count", 64'(wr_count), 64'(exp_wr));
    chk("rand_overflow", 64'(overflow), 64'd0);

    // Almost-full and overflow with the c0 pop parked
    force dut.w_c0_pop_hold = 1'b1;
    for (int k = 1; k <= 17; k++) begin
      c0_tx_valid = 1'b1;
      c0_tx_addr  = 42'(k);
      c0_tx_mdata = 16'(16'h0100 + k);
      if (k <= 16) begin
        r.m = c0_tx_mdata; r.d = mem_model[k]; r.c = 0; r.t = 1'b0;
        rdq.push_back(r);
        exp_rd++;
      end
      @(posedge clk);
      @(negedge clk);
      occ = (k > 16) ? 16 : k;
      chk("stall_alm_full", 64'(c0_tx_alm_full), 64'(occ >= 8));
      chk("stall_rd_count", 64'(rd_count), 64'(exp_rd));
      chk("stall_overflow", 64'(overflow), 64'(k == 17));
    end
    c0_tx_valid = 1'b0;
    @(posedge clk); #1;
    release dut.w_c0_pop_hold;
    wait_drain(200);
    chk("drain_alm_full", 64'(c0_tx_alm_full), 64'd0);
    chk("overflow_sticky", 64'(overflow), 64'd1);

    // Reset mid-flight: parked reads must never respond
    force dut.w_c0_pop_hold = 1'b1;
    for (int k = 0; k < 4; k++) begin
      c0_tx_valid = 1'b1;
      c0_tx_addr  = 42'(k + 20);
      c0_tx_mdata = 16'(16'h0E00 + k);
      @(posedge clk); #1;
    end
    c0_tx_valid = 1'b0;
    reset = 1'b1;
    release dut.w_c0_pop_hold;
    @(posedge clk); #1;
    @(posedge clk);
    @(negedge clk);
    chk("mid_rst_rd_count", 64'(rd_count), 64'd0);
    chk("mid_rst_wr_count", 64'(wr_count), 64'd0);
    chk("mid_rst_c0_alm", 64'(c0_tx_alm_full), 64'd0);
    chk("mid_rst_overflow", 64'(overflow), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    exp_rd = 0;
    exp_wr = 0;
    repeat (RD_LAT + 10) begin @(posedge clk); #1; end

    // Memory survives reset
    rd(42'h3, 16'h0F03);
    rd(42'h14, 16'h0F14);
    wr(42'h9, 16'h0F09, rnd512());
    rd(42'h9, 16'h0F19);
    wait_drain(200);
    chk("post_rd_count", 64'(rd_count), 64'd3);
    chk("post_wr_count", 64'(wr_count), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
